// File: rtl/gsim_pkg.sv
`default_nettype none
// ============================================================================
// gsim_pkg : shared types and helpers for the Gauss-Seidel solver
// Rev 1.0
// ============================================================================
package gsim_pkg;

    localparam int C_N_DEF        = 16;
    localparam int C_COEF_W_DEF   = 16;
    localparam int C_X_W_DEF      = 32;
    localparam int C_X_FRAC_DEF   = 16;
    localparam int C_INV_FRAC_DEF = 14;
    localparam int C_SAT_W        = 128;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_B    = 3'd1,
        S_ROW_REQ   = 3'd2,
        S_ROW_WAIT  = 3'd3,
        S_SWEEP_END = 3'd4,
        S_WRITE     = 3'd5,
        S_STAT      = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    // Clamp a wide signed value to the signed range of an xw-bit word.
    function automatic logic signed [C_SAT_W-1:0] sat_xw(
        input logic signed [C_SAT_W-1:0] v,
        input int                        xw
    );
        logic signed [C_SAT_W-1:0] lo;
        logic signed [C_SAT_W-1:0] hi;
        lo = {C_SAT_W{1'b1}} << (xw - 1);
        hi = ~lo;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    function automatic logic [31:0] mat_base(input logic [31:0] m, input int n);
        return m * 32'(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gsim_row_mac.sv
`default_nettype none
// ============================================================================
// gsim_row_mac : combinational row update x_r = sat((b<<F - sum a*x) * inv)
// Rev 1.0
// ============================================================================
module gsim_row_mac
    import gsim_pkg::*;
#(
    parameter int N        = C_N_DEF,
    parameter int COEF_W   = C_COEF_W_DEF,
    parameter int X_W      = C_X_W_DEF,
    parameter int X_FRAC   = C_X_FRAC_DEF,
    parameter int INV_FRAC = C_INV_FRAC_DEF,
    parameter int R_W      = $clog2(N)
)(
    input  logic [N*COEF_W-1:0]      i_row,
    input  logic [N*X_W-1:0]         i_x,
    input  logic signed [COEF_W-1:0] i_b,
    input  logic [R_W-1:0]           i_r,
    output logic signed [X_W-1:0]    o_x_new
);

    localparam int PROD_W = COEF_W + X_W;
    localparam int ACC_W  = COEF_W + X_W + $clog2(N);

    logic signed [ACC_W-1:0]         w_prod [N];
    logic signed [ACC_W-1:0]         w_sum;
    logic signed [ACC_W-1:0]         w_acc;
    logic signed [X_W-1:0]           w_t;
    logic signed [COEF_W-1:0]        w_inv;
    logic signed [X_W+COEF_W-1:0]    w_p2;
    logic signed [X_W+COEF_W-1:0]    w_shift;

    // The diagonal slot carries 1/a_rr, so it is masked out of the sum.
    generate
        for (genvar j = 0; j < N; j++) begin : g_prod
            logic signed [COEF_W-1:0] w_a;
            logic signed [X_W-1:0]    w_xj;
            logic signed [PROD_W-1:0] w_p;
            assign w_a  = i_row[COEF_W*j +: COEF_W];
            assign w_xj = i_x[X_W*j +: X_W];
            assign w_p  = w_a * w_xj;
            assign w_prod[j] = (i_r == R_W'(j)) ? '0 : ACC_W'(w_p);
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N; j++) begin
            w_sum = w_sum + w_prod[j];
        end
    end

    assign w_acc   = (ACC_W'(i_b) <<< X_FRAC) - w_sum;
    assign w_t     = X_W'(sat_xw(C_SAT_W'(w_acc), X_W));
    assign w_inv   = i_row[COEF_W*i_r +: COEF_W];
    assign w_p2    = w_t * w_inv;
    assign w_shift = w_p2 >>> INV_FRAC;
    assign o_x_new = X_W'(sat_xw(C_SAT_W'(w_shift), X_W));

endmodule
`default_nettype wire

// File: rtl/gsim_solver_param.sv
`default_nettype none
// ============================================================================
// gsim_solver_param : fixed-point Gauss-Seidel solver, one matrix after another
// Rev 1.0
// ============================================================================
module gsim_solver_param
    import gsim_pkg::*;
#(
    parameter int N        = C_N_DEF,
    parameter int COEF_W   = C_COEF_W_DEF,
    parameter int X_W      = C_X_W_DEF,
    parameter int X_FRAC   = C_X_FRAC_DEF,
    parameter int INV_FRAC = C_INV_FRAC_DEF,
    parameter int ITER_W   = 5,
    parameter int MAT_W    = 5,
    parameter int MADDR_W  = 10,
    parameter int XADDR_W  = 9
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_module_en,
    input  logic [MAT_W-1:0]      i_matrix_num,
    input  logic [ITER_W-1:0]     i_max_iter,
    input  logic [X_W-1:0]        i_tol,
    input  logic                  i_tol_en,
    output logic                  o_proc_done,
    output logic                  o_mem_rreq,
    output logic [MADDR_W-1:0]    o_mem_addr,
    input  logic                  i_mem_rrdy,
    input  logic [N*COEF_W-1:0]   i_mem_dout,
    input  logic                  i_mem_dout_vld,
    output logic                  o_x_wen,
    output logic [XADDR_W-1:0]    o_x_addr,
    output logic [X_W-1:0]        o_x_data,
    output logic                  o_stat_vld,
    output logic [ITER_W-1:0]     o_stat_iters,
    output logic                  o_stat_conv
);

    localparam int              R_W      = $clog2(N);
    localparam logic [R_W-1:0]  C_R_LAST = R_W'(N - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [MAT_W-1:0]           r_m;
    logic [R_W-1:0]             r_r;
    logic [ITER_W-1:0]          r_iter;
    logic                       r_conv;
    logic                       r_acc;
    logic [N-1:0][X_W-1:0]      r_x;
    logic [N-1:0][COEF_W-1:0]   r_b;
    logic [X_W:0]               r_dmax;

    logic signed [X_W-1:0]      w_x_new;
    logic signed [X_W-1:0]      w_x_old;
    logic signed [X_W:0]        w_diff;
    logic [X_W:0]               w_adiff;
    logic [ITER_W-1:0]          w_iter_inc;
    logic [ITER_W-1:0]          w_iter_lim;
    logic                       w_conv;
    logic                       w_stop;
    logic                       w_abort;

    gsim_row_mac #(
        .N        (N),
        .COEF_W   (COEF_W),
        .X_W      (X_W),
        .X_FRAC   (X_FRAC),
        .INV_FRAC (INV_FRAC),
        .R_W      (R_W)
    ) u_row_mac (
        .i_row    (i_mem_dout),
        .i_x      (r_x),
        .i_b      (r_b[r_r]),
        .i_r      (r_r),
        .o_x_new  (w_x_new)
    );

    // Delta is taken one bit wider so full-scale swings cannot wrap.
    assign w_x_old    = r_x[r_r];
    assign w_diff     = {w_x_new[X_W-1], w_x_new} - {w_x_old[X_W-1], w_x_old};
    assign w_adiff    = w_diff[X_W] ? -w_diff : w_diff;
    assign w_iter_inc = r_iter + ITER_W'(1);
    assign w_iter_lim = (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
    assign w_conv     = i_tol_en && (r_dmax <= {1'b0, i_tol});
    assign w_stop     = w_conv || (w_iter_inc == w_iter_lim);
    assign w_abort    = !i_module_en && (r_state != S_IDLE) && (r_state != S_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_mem_rreq   = 1'b0;
        o_mem_addr   = '0;
        o_x_wen      = 1'b0;
        o_x_addr     = '0;
        o_x_data     = '0;
        o_stat_vld   = 1'b0;
        o_stat_iters = '0;
        o_stat_conv  = 1'b0;
        o_proc_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_module_en)
                    w_state_nxt = (i_matrix_num == '0) ? S_DONE : S_LOAD_B;
            end
            S_LOAD_B: begin
                if (!r_acc) begin
                    o_mem_rreq = 1'b1;
                    o_mem_addr = MADDR_W'(mat_base(32'(r_m), N) + 32'(N));
                end
                if (r_acc && i_mem_dout_vld) w_state_nxt = S_ROW_REQ;
            end
            S_ROW_REQ: begin
                o_mem_rreq = 1'b1;
                o_mem_addr = MADDR_W'(mat_base(32'(r_m), N) + 32'(r_r));
                if (i_mem_rrdy) w_state_nxt = S_ROW_WAIT;
            end
            S_ROW_WAIT: begin
                if (i_mem_dout_vld)
                    w_state_nxt = (r_r == C_R_LAST) ? S_SWEEP_END : S_ROW_REQ;
            end
            S_SWEEP_END: begin
                w_state_nxt = w_stop ? S_WRITE : S_ROW_REQ;
            end
            S_WRITE: begin
                o_x_wen  = 1'b1;
                o_x_addr = XADDR_W'(32'(r_m) * 32'(N) + 32'(r_r));
                o_x_data = r_x[r_r];
                if (r_r == C_R_LAST) w_state_nxt = S_STAT;
            end
            S_STAT: begin
                o_stat_vld   = 1'b1;
                o_stat_iters = r_iter;
                o_stat_conv  = r_conv;
                w_state_nxt  = ((r_m + MAT_W'(1)) == i_matrix_num) ? S_DONE : S_LOAD_B;
            end
            S_DONE: begin
                o_proc_done = 1'b1;
                if (!i_module_en) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m    <= '0;
            r_r    <= '0;
            r_iter <= '0;
            r_conv <= 1'b0;
            r_acc  <= 1'b0;
            r_x    <= '0;
            r_b    <= '0;
            r_dmax <= '0;
        end else if (w_abort) begin
            r_acc <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_m   <= '0;
                    r_acc <= 1'b0;
                end
                S_LOAD_B: begin
                    if (o_mem_rreq && i_mem_rrdy) r_acc <= 1'b1;
                    if (r_acc && i_mem_dout_vld) begin
                        r_b    <= i_mem_dout;
                        r_x    <= '0;
                        r_dmax <= '0;
                        r_iter <= '0;
                        r_r    <= '0;
                        r_acc  <= 1'b0;
                    end
                end
                S_ROW_WAIT: begin
                    if (i_mem_dout_vld) begin
                        r_x[r_r] <= w_x_new;
                        if (w_adiff > r_dmax) r_dmax <= w_adiff;
                        if (r_r != C_R_LAST) r_r <= r_r + R_W'(1);
                    end
                end
                S_SWEEP_END: begin
                    r_iter <= w_iter_inc;
                    r_conv <= w_conv;
                    r_r    <= '0;
                    if (!w_stop) r_dmax <= '0;
                end
                S_WRITE: begin
                    r_r <= (r_r == C_R_LAST) ? '0 : r_r + R_W'(1);
                end
                S_STAT: begin
                    r_m <= r_m + MAT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
